ram_pattern_writer: RTL and testbench

Parametrised RAM write sequencer that drives a wide multi-word write port with generated data patterns for memory bring-up and bandwidth testing. It generalises the fixed 4×16-bit incrementing writer into a start/done-controlled engine with configurable width, beat count, base address, pattern mode, per-run byte enables, and write-ready backpressure. It sits between the test controller (start, abort, done) and the RAM write port.

---
 rtl/ram_writer_pkg.sv | 24 ++
 rtl/ram_pattern_gen.sv | 54 +++++
 rtl/ram_pattern_writer.sv | 182 ++++++++++++++++++
 tb/tb_ram_pattern_writer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_writer_pkg.sv
// rtl/ram_writer_pkg.sv - shared states, pattern mode encodings and LFSR step for the RAM pattern writer
package ram_writer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_WRITE,
    ST_GAP,
    ST_DONE
  } state_e;

  localparam logic [1:0] MODE_INCR  = 2'd0;
  localparam logic [1:0] MODE_CONST = 2'd1;
  localparam logic [1:0] MODE_ADDR  = 2'd2;
  localparam logic [1:0] MODE_LFSR  = 2'd3;

  localparam logic [15:0] LFSR_POLY = 16'hB400;

  // Left-shifting Galois step: the bit falling out of the MSB folds the taps back in.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    lfsr_step = {s[14:0], 1'b0} ^ (s[15] ? LFSR_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/ram_pattern_gen.sv
// rtl/ram_pattern_gen.sv - combinational beat data generator; LFSR mode only with RAM_PATTERN_WRITER_LFSR_EN
module ram_pattern_gen
  import ram_writer_pkg::*;
#(
  parameter int ADDR_W    = 14,
  parameter int WORD_W    = 16,
  parameter int NUM_WORDS = 4
) (
  input  logic [1:0]                  mode_i,
  input  logic [WORD_W-1:0]           seed_i,
  input  logic [ADDR_W:0]             beat_i,
  input  logic [ADDR_W-1:0]           addr_i,
  output logic [NUM_WORDS*WORD_W-1:0] data_o
`ifdef RAM_PATTERN_WRITER_LFSR_EN
  ,
  input  logic [15:0]                 lfsr_i,
  output logic [15:0]                 lfsr_o
`endif
);

`ifdef RAM_PATTERN_WRITER_LFSR_EN
  if (WORD_W != 16) begin : g_word_w_check
    $error("LFSR pattern mode requires WORD_W == 16");
  end
  logic [15:0] lfsr_s;
`endif

  logic [WORD_W-1:0] incr_base;

  always_comb begin
    incr_base = seed_i + WORD_W'(beat_i) * WORD_W'(NUM_WORDS);
    data_o    = '0;
`ifdef RAM_PATTERN_WRITER_LFSR_EN
    lfsr_s    = lfsr_i;
`endif
    for (int k = 0; k < NUM_WORDS; k++) begin
`ifdef RAM_PATTERN_WRITER_LFSR_EN
      lfsr_s = lfsr_step(lfsr_s);
`endif
      case (mode_i)
        MODE_CONST: data_o[k*WORD_W +: WORD_W] = seed_i;
        MODE_ADDR:  data_o[k*WORD_W +: WORD_W] = WORD_W'(addr_i);
`ifdef RAM_PATTERN_WRITER_LFSR_EN
        MODE_LFSR:  data_o[k*WORD_W +: WORD_W] = WORD_W'(lfsr_s);
`endif
        default:    data_o[k*WORD_W +: WORD_W] = incr_base + WORD_W'(k);
      endcase
    end
`ifdef RAM_PATTERN_WRITER_LFSR_EN
    lfsr_o = lfsr_s;
`endif
  end

endmodule

// File: rtl/ram_pattern_writer.sv
// rtl/ram_pattern_writer.sv - start/done RAM write sequencer with pattern data; LFSR mode via RAM_PATTERN_WRITER_LFSR_EN
module ram_pattern_writer
  import ram_writer_pkg::*;
#(
  parameter int ADDR_W      = 14,
  parameter int WORD_W      = 16,
  parameter int NUM_WORDS   = 4,
  parameter int INIT_CYCLES = 5,
  parameter int BE_W        = NUM_WORDS*WORD_W/8
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_start,
  input  logic                        i_abort,
  input  logic [ADDR_W-1:0]           i_base_addr,
  input  logic [ADDR_W:0]             i_count,
  input  logic [1:0]                  i_mode,
  input  logic [WORD_W-1:0]           i_seed,
  input  logic [BE_W-1:0]             i_byteen,
  input  logic                        i_ready,
  output logic                        o_wen,
  output logic [ADDR_W-1:0]           o_addr,
  output logic [NUM_WORDS*WORD_W-1:0] o_data,
  output logic [BE_W-1:0]             o_byteen,
  output logic                        o_busy,
  output logic                        o_done,
  output logic [ADDR_W:0]             o_beats
);

  localparam int DATA_W = NUM_WORDS*WORD_W;
  localparam int CNT_W  = ADDR_W + 1;
  localparam int SET_W  = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d, gen_data;
  logic [BE_W-1:0]     byteen_q, byteen_d;
  logic [CNT_W-1:0]    beats_q, beats_d, count_q, count_d;
  logic [1:0]          mode_q, mode_d;
  logic [WORD_W-1:0]   seed_q, seed_d;
  logic [SET_W-1:0]    settle_q, settle_d;
  logic                wen_q, wen_d, busy_q, busy_d, done_q, done_d;
  logic                commit, load;
`ifdef RAM_PATTERN_WRITER_LFSR_EN
  logic [15:0]         lfsr_q, lfsr_d, gen_lfsr;
`endif

  // Generator sees the already-advanced address and beat index, so its output is the next beat.
  ram_pattern_gen #(
    .ADDR_W    (ADDR_W),
    .WORD_W    (WORD_W),
    .NUM_WORDS (NUM_WORDS)
  ) u_gen (
    .mode_i (mode_q),
    .seed_i (seed_q),
    .beat_i (beats_q),
    .addr_i (addr_q),
    .data_o (gen_data)
`ifdef RAM_PATTERN_WRITER_LFSR_EN
    ,
    .lfsr_i (lfsr_q),
    .lfsr_o (gen_lfsr)
`endif
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    byteen_d = byteen_q;
    beats_d  = beats_q;
    count_d  = count_q;
    mode_d   = mode_q;
    seed_d   = seed_q;
    settle_d = settle_q;
    load     = 1'b0;
    commit   = wen_q && i_ready;
`ifdef RAM_PATTERN_WRITER_LFSR_EN
    lfsr_d   = lfsr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          addr_d   = i_base_addr;
          count_d  = i_count;
          mode_d   = i_mode;
          seed_d   = i_seed;
          byteen_d = i_byteen;
          beats_d  = '0;
          settle_d = SET_W'(INIT_CYCLES - 1);
`ifdef RAM_PATTERN_WRITER_LFSR_EN
          lfsr_d   = (i_seed == '0) ? 16'd1 : 16'(i_seed);
`endif
          state_d  = (i_count == '0) ? ST_DONE : ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (i_abort) begin
          state_d = ST_DONE;
        end else if (settle_q == '0) begin
          state_d = ST_WRITE;
          load    = 1'b1;
        end else begin
          settle_d = settle_q - SET_W'(1);
        end
      end
      ST_WRITE: begin
        if (commit) begin
          beats_d = beats_q + CNT_W'(1);
          addr_d  = addr_q + ADDR_W'(1);
          state_d = i_abort ? ST_DONE : ST_GAP;
        end else if (i_abort) begin
          state_d = ST_DONE;
        end
      end
      ST_GAP: begin
        if (i_abort || beats_q == count_q) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_WRITE;
          load    = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (load) begin
      data_d = gen_data;
`ifdef RAM_PATTERN_WRITER_LFSR_EN
      lfsr_d = gen_lfsr;
`endif
    end
    wen_d  = (state_d == ST_WRITE);
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      byteen_q <= '0;
      beats_q  <= '0;
      count_q  <= '0;
      mode_q   <= '0;
      seed_q   <= '0;
      settle_q <= '0;
      wen_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef RAM_PATTERN_WRITER_LFSR_EN
      lfsr_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      byteen_q <= byteen_d;
      beats_q  <= beats_d;
      count_q  <= count_d;
      mode_q   <= mode_d;
      seed_q   <= seed_d;
      settle_q <= settle_d;
      wen_q    <= wen_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef RAM_PATTERN_WRITER_LFSR_EN
      lfsr_q   <= lfsr_d;
`endif
    end
  end

  assign o_wen    = wen_q;
  assign o_addr   = addr_q;
  assign o_data   = data_q;
  assign o_byteen = byteen_q;
  assign o_busy   = busy_q;
  assign o_done   = done_q;
  assign o_beats  = beats_q;

endmodule

// File: tb/tb_ram_pattern_writer.sv
// tb/tb_ram_pattern_writer.sv - table, hand-sequence and randomized checks of ram_pattern_writer
module tb_ram_pattern_writer;

  localparam int ADDR_W = 14, WORD_W = 16, NUM_WORDS = 4, INIT_CYCLES = 5, BE_W = 8;

  logic        clk, i_rst, i_start, i_abort, i_ready;
  logic [13:0] i_base_addr;
  logic [14:0] i_count;
  logic [1:0]  i_mode;
  logic [15:0] i_seed;
  logic [7:0]  i_byteen;
  logic        o_wen, o_busy, o_done;
  logic [13:0] o_addr;
  logic [63:0] o_data;
  logic [7:0]  o_byteen;
  logic [14:0] o_beats;

  ram_pattern_writer #(
    .ADDR_W(ADDR_W), .WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS), .INIT_CYCLES(INIT_CYCLES), .BE_W(BE_W)
  ) dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort),
    .i_base_addr(i_base_addr), .i_count(i_count), .i_mode(i_mode), .i_seed(i_seed),
    .i_byteen(i_byteen), .i_ready(i_ready), .o_wen(o_wen), .o_addr(o_addr),
    .o_data(o_data), .o_byteen(o_byteen), .o_busy(o_busy), .o_done(o_done), .o_beats(o_beats)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_ref(input logic [15:0] seed, input int steps);
    logic [15:0] s;
    s = (seed == 16'h0) ? 16'h0001 : seed;
    for (int i = 0; i < steps; i++)
      s = s[15] ? ((s << 1) ^ 16'hB400) : (s << 1);
    return s;
  endfunction

  function automatic logic [15:0] exp_word(input logic [1:0] mode, input logic [15:0] seed,
                                           input int n, input logic [13:0] addr, input int k);
    case (mode)
      2'd1: return seed;
      2'd2: return {2'b00, addr};
`ifdef RAM_PATTERN_WRITER_LFSR_EN
      2'd3: return lfsr_ref(seed, n*NUM_WORDS + k + 1);
`endif
      default: return seed + 16'(n*NUM_WORDS + k);
    endcase
  endfunction

  task automatic do_run(input logic [13:0] base, input logic [14:0] count, input logic [1:0] mode,
                        input logic [15:0] seed, input logic [7:0] be, input bit rand_ready,
                        input int stall_beat, input int stall_len, input int abort_beat,
                        input bit poke_start, output int beats_seen, output logic [13:0] last_addr,
                        output logic [63:0] last_data, output int stall_wen);
    int cyc, first_wen, last_commit, done_cyc, n, stall_cnt, exp_n, exp_done;
    bit aborted, r;
    logic [13:0] ea;
    logic [63:0] ed;
    last_addr = '0; last_data = '0;
    @(negedge clk);
    i_base_addr = base; i_count = count; i_mode = mode; i_seed = seed; i_byteen = be;
    i_start = 1'b1; i_abort = 1'b0; i_ready = 1'b0;
    @(negedge clk);
    i_start = 1'b0;
    cyc = 1; n = 0; first_wen = -1; last_commit = -1; done_cyc = -1;
    aborted = 0; stall_cnt = 0; stall_wen = 0;
    if (count == 0) exp_n = 0;
    else if (abort_beat >= 0 && abort_beat < int'(count)) exp_n = abort_beat + 1;
    else exp_n = int'(count);
    while (done_cyc < 0 && cyc < 3000) begin
      if (last_commit >= 0 && last_commit == cyc - 1) check("gap_no_wen", o_wen, 0);
      check("busy", o_busy, 1);
      if (o_done) begin
        done_cyc = cyc;
        check("done_no_wen", o_wen, 0);
      end else begin
        if (poke_start && cyc == 2) begin
          i_start = 1'b1; i_base_addr = ~base; i_count = 15'd1; i_mode = ~mode;
        end
        if (o_wen) begin
          if (first_wen < 0) begin
            first_wen = cyc;
            check("first_wen_cycle", cyc, INIT_CYCLES + 1);
          end
          ea = base + 14'(n);
          for (int k = 0; k < NUM_WORDS; k++) ed[k*16 +: 16] = exp_word(mode, seed, n, ea, k);
          check("addr", o_addr, ea);
          check("data", o_data, ed);
          check("byteen", o_byteen, be);
          if (n == stall_beat && stall_cnt < stall_len) begin
            r = 1'b0; stall_cnt++;
          end else begin
            r = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
          end
          if (n == stall_beat) stall_wen++;
          i_ready = r;
          if (r) begin
            last_addr = o_addr; last_data = o_data;
            if (n == abort_beat) begin i_abort = 1'b1; aborted = 1; end
            last_commit = cyc;
            n++;
          end
        end else begin
          i_ready = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        i_abort = 1'b0; i_start = 1'b0;
        cyc++;
      end
    end
    check("done_seen", done_cyc >= 0, 1);
    if (count == 0) exp_done = 1;
    else if (aborted) exp_done = last_commit + 1;
    else exp_done = last_commit + 2;
    check("done_cycle", done_cyc, exp_done);
    check("commits", n, exp_n);
    check("o_beats", o_beats, exp_n);
    beats_seen = n;
    @(negedge clk);
    check("done_pulse_end", o_done, 0);
    check("busy_end", o_busy, 0);
  endtask

  typedef struct {
    logic [13:0] base;
    logic [14:0] count;
    logic [1:0]  mode;
    logic [15:0] seed;
    logic [7:0]  be;
    int          exp_beats;
    logic [13:0] exp_last_addr;
    logic [63:0] exp_last_data;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int bs, sw, w, ab;
    logic [13:0] la;
    logic [63:0] ld;

    vecs[0] = '{14'h0000, 15'd4, 2'd0, 16'h0000, 8'hFF, 4, 14'h0003, 64'h000F_000E_000D_000C};
    vecs[1] = '{14'h3FFE, 15'd3, 2'd2, 16'h1234, 8'h0F, 3, 14'h0000, 64'h0000_0000_0000_0000};
    vecs[2] = '{14'h0100, 15'd2, 2'd1, 16'hA5A5, 8'hA5, 2, 14'h0101, 64'hA5A5_A5A5_A5A5_A5A5};
    vecs[3] = '{14'h0010, 15'd5, 2'd0, 16'hFFFE, 8'h3C, 5, 14'h0014, 64'h0011_0010_000F_000E};
    vecs[4] = '{14'h0200, 15'd0, 2'd0, 16'h5555, 8'h00, 0, 14'h0000, 64'h0};
`ifdef RAM_PATTERN_WRITER_LFSR_EN
    vecs[5] = '{14'h0020, 15'd1, 2'd3, 16'h0000, 8'h81, 1, 14'h0020, 64'h0010_0008_0004_0002};
`else
    vecs[5] = '{14'h0020, 15'd1, 2'd3, 16'h0000, 8'h81, 1, 14'h0020, 64'h0003_0002_0001_0000};
`endif

    i_rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_ready = 1'b0;
    i_base_addr = '0; i_count = '0; i_mode = '0; i_seed = '0; i_byteen = '0;
    repeat (3) @(negedge clk);
    check("rst_wen", o_wen, 0);
    check("rst_addr", o_addr, 0);
    check("rst_data", o_data, 0);
    check("rst_byteen", o_byteen, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_beats", o_beats, 0);
    i_rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      do_run(vecs[i].base, vecs[i].count, vecs[i].mode, vecs[i].seed, vecs[i].be,
             0, -1, 0, -1, 0, bs, la, ld, sw);
      check("tbl_beats", bs, vecs[i].exp_beats);
      if (vecs[i].exp_beats > 0) begin
        check("tbl_last_addr", la, vecs[i].exp_last_addr);
        check("tbl_last_data", ld, vecs[i].exp_last_data);
      end
    end

    do_run(14'h0300, 15'd3, 2'd1, 16'hA5A5, 8'hFF, 0, 1, 3, -1, 0, bs, la, ld, sw);
    check("stall_hold_cycles", sw, 4);
    check("stall_beats", bs, 3);

    do_run(14'h0040, 15'd6, 2'd0, 16'h1234, 8'h0F, 0, -1, 0, 2, 0, bs, la, ld, sw);
    check("abort_beats", bs, 3);

    do_run(14'h0080, 15'd2, 2'd2, 16'h0000, 8'hFF, 0, -1, 0, -1, 1, bs, la, ld, sw);
    check("busy_start_ignored", bs, 2);

    @(negedge clk);
    i_base_addr = 14'h0155; i_count = 15'd4; i_mode = 2'd0; i_seed = 16'h1111; i_byteen = 8'hFF;
    i_ready = 1'b0; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    w = 0;
    while (!o_wen && w < 50) begin @(negedge clk); w++; end
    check("rst_reach_write", o_wen, 1);
    i_rst = 1'b1;
    @(negedge clk);
    check("midrst_wen", o_wen, 0);
    check("midrst_addr", o_addr, 0);
    check("midrst_data", o_data, 0);
    check("midrst_byteen", o_byteen, 0);
    check("midrst_busy", o_busy, 0);
    check("midrst_done", o_done, 0);
    check("midrst_beats", o_beats, 0);
    i_rst = 1'b0;
    @(negedge clk);
    check("midrst_idle", o_busy, 0);

    for (int i = 0; i < 24; i++) begin
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1;
      do_run(14'($urandom), 15'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 16'($urandom),
             8'($urandom), 1, -1, 0, ab, 0, bs, la, ld, sw);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
